// File: rtl/invsqrt_pkg.sv
// rtl/invsqrt_pkg.sv - shared error codes and default seed constants for the inverse-sqrt seed pipe
package invsqrt_pkg;

   localparam logic [2:0] ERR_OK     = 3'd0;
   localparam logic [2:0] ERR_ZERO   = 3'd1;
   localparam logic [2:0] ERR_NEG    = 3'd2;
   localparam logic [2:0] ERR_INF    = 3'd3;
   localparam logic [2:0] ERR_NAN    = 3'd4;
   localparam logic [2:0] ERR_DENORM = 3'd5;

   localparam logic [31:0] MAGIC_FP32 = 32'h5F3759DF;
   localparam logic [15:0] MAGIC_FP16 = 16'h59BA;

endpackage

// File: rtl/invsqrt_seed_lane.sv
// rtl/invsqrt_seed_lane.sv - per-lane operand classification and seed/halve arithmetic (combinational)
module invsqrt_seed_lane
   import invsqrt_pkg::*;
#(
   parameter int                   EXP_W = 8,
   parameter int                   MAN_W = 23,
   parameter logic [EXP_W+MAN_W:0] MAGIC = MAGIC_FP32
) (
   input  logic [EXP_W+MAN_W:0] raw,
   output logic [2:0]           raw_code,
   input  logic [EXP_W+MAN_W:0] op,
   input  logic [2:0]           code,
   output logic [EXP_W+MAN_W:0] y,
   output logic [EXP_W+MAN_W:0] x2
);

   localparam int W = 1 + EXP_W + MAN_W;

   logic [EXP_W-1:0] exp_r;
   logic [MAN_W-1:0] man_r;
   logic [EXP_W-1:0] exp_o;
   logic [MAN_W-1:0] man_o;

   assign exp_r = raw[W-2 -: EXP_W];
   assign man_r = raw[MAN_W-1:0];
   assign exp_o = op[W-2 -: EXP_W];
   assign man_o = op[MAN_W-1:0];

   // Classification is ordered: the first matching rule wins.
   always_comb begin
      raw_code = ERR_OK;
      if ((&exp_r) && (|man_r))
         raw_code = ERR_NAN;
      else if (raw[W-1] && (|raw[W-2:0]))
         raw_code = ERR_NEG;
      else if (!(|raw[W-2:0]))
         raw_code = ERR_ZERO;
      else if (&exp_r)
         raw_code = ERR_INF;
      else if (exp_r == '0)
         raw_code = ERR_DENORM;
   end

   always_comb begin
      y  = '0;
      x2 = '0;
      case (code)
         ERR_OK: begin
            y = MAGIC - (op >> 1);
            // exp==1 halves into the denormal range instead of wrapping the exponent
            if (exp_o == {{(EXP_W-1){1'b0}}, 1'b1})
               x2 = {1'b0, {EXP_W{1'b0}}, 1'b1, man_o[MAN_W-1:1]};
            else
               x2 = {1'b0, exp_o - {{(EXP_W-1){1'b0}}, 1'b1}, man_o};
         end
         ERR_ZERO, ERR_DENORM: y = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         ERR_NEG, ERR_NAN:     y = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
         default:              y = '0;
      endcase
   end

endmodule

// File: rtl/invsqrt_seed_pipe.sv
// rtl/invsqrt_seed_pipe.sv - two-stage multi-lane inverse-sqrt seed pipeline with valid/ready handshake
module invsqrt_seed_pipe
   import invsqrt_pkg::*;
#(
   parameter int                   EXP_W = 8,
   parameter int                   MAN_W = 23,
   parameter int                   LANES = 1,
   parameter logic [EXP_W+MAN_W:0] MAGIC = MAGIC_FP32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [LANES*(1+EXP_W+MAN_W)-1:0] out_y,
   output logic [LANES*(1+EXP_W+MAN_W)-1:0] out_x2,
   output logic [LANES*3-1:0]               out_err
);

   localparam int W = 1 + EXP_W + MAN_W;

   logic               s1_valid;
   logic [LANES*W-1:0] s1_op;
   logic [LANES*3-1:0] s1_code;
   logic               s2_valid;
   logic               s1_adv;
   logic               s2_adv;

   logic [LANES*3-1:0] lane_code;
   logic [LANES*W-1:0] lane_y;
   logic [LANES*W-1:0] lane_x2;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      invsqrt_seed_lane #(
         .EXP_W (EXP_W),
         .MAN_W (MAN_W),
         .MAGIC (MAGIC)
      ) u_lane (
         .raw      (in_data[i*W +: W]),
         .raw_code (lane_code[i*3 +: 3]),
         .op       (s1_op[i*W +: W]),
         .code     (s1_code[i*3 +: 3]),
         .y        (lane_y[i*W +: W]),
         .x2       (lane_x2[i*W +: W])
      );
   end

   // Ready ripples back combinationally so a full pipe still moves one item per cycle.
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_code  <= '0;
         s2_valid <= 1'b0;
         out_y    <= '0;
         out_x2   <= '0;
         out_err  <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_op   <= in_data;
               s1_code <= lane_code;
            end
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               out_y   <= lane_y;
               out_x2  <= lane_x2;
               out_err <= s1_code;
            end
         end
      end
   end

endmodule

// File: tb/tb_invsqrt_seed_pipe.sv
// tb/tb_invsqrt_seed_pipe.sv - self-checking bench for invsqrt_seed_pipe (4-lane FP32 and 1-lane FP16)
module tb_invsqrt_seed_pipe;

   typedef struct {
      logic [127:0] y;
      logic [127:0] x2;
      logic [11:0]  err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_y;
   logic [127:0] out_x2;
   logic [11:0]  out_err;

   logic         h_in_valid;
   logic         h_in_ready;
   logic [15:0]  h_in_data;
   logic         h_out_valid;
   logic         h_out_ready;
   logic [15:0]  h_out_y;
   logic [15:0]  h_out_x2;
   logic [2:0]   h_out_err;

   int passed = 0;
   int total  = 0;
   int accepted = 0;
   int emitted  = 0;
   bit acc_now;
   bit stall_prev = 1'b0;
   bit track_drop = 1'b0;
   bit drop_seen  = 1'b0;
   logic [287:0] prev_bundle;
   exp_t sb[$];

   always #5 clk = ~clk;

   invsqrt_seed_pipe #(.EXP_W(8), .MAN_W(23), .LANES(4), .MAGIC(32'h5F3759DF)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_x2(out_x2), .out_err(out_err)
   );

   invsqrt_seed_pipe #(.EXP_W(5), .MAN_W(10), .LANES(1), .MAGIC(16'h59BA)) dut16 (
      .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
      .out_valid(h_out_valid), .out_ready(h_out_ready), .out_y(h_out_y), .out_x2(h_out_x2),
      .out_err(h_out_err)
   );

   task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // Reference: IEEE field rules applied with plain integer arithmetic on the whole word.
   function automatic void model_lane(input logic [31:0] x, output logic [31:0] y,
                                      output logic [31:0] x2, output logic [2:0] err);
      logic [7:0]  e = x[30:23];
      logic [22:0] m = x[22:0];
      x2 = 32'h0;
      if (e == 8'hFF && m != 0)        begin err = 3'd4; y = 32'h7FC00000; end
      else if (x[31] && x[30:0] != 0)  begin err = 3'd2; y = 32'h7FC00000; end
      else if (x[30:0] == 0)           begin err = 3'd1; y = 32'h7F800000; end
      else if (e == 8'hFF)             begin err = 3'd3; y = 32'h00000000; end
      else if (e == 8'h00)             begin err = 3'd5; y = 32'h7F800000; end
      else begin
         err = 3'd0;
         y   = 32'h5F3759DF - x / 2;
         x2  = (e >= 2) ? x - 32'h00800000 : x / 2;
      end
   endfunction

   function automatic exp_t model_vec(input logic [127:0] d);
      exp_t r;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] y, x2;
         logic [2:0]  err;
         model_lane(d[i*32 +: 32], y, x2, err);
         r.y[i*32 +: 32]  = y;
         r.x2[i*32 +: 32] = x2;
         r.err[i*3 +: 3]  = err;
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 9))
         0:       return 32'h00000000;
         1:       return 32'h80000000;
         2:       return 32'h7F800000;
         3:       return 32'hFF800000;
         4:       return 32'h7F800000 | $urandom_range(1, 32'h7FFFFF);
         5:       return $urandom_range(1, 32'h7FFFFF);
         6:       return $urandom;
         7:       return 32'h00800000 | ($urandom & 32'h007FFFFF);
         default: return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      endcase
   endfunction

   function automatic logic [127:0] rand_vec();
      return {rand_op(), rand_op(), rand_op(), rand_op()};
   endfunction

   task automatic observe();
      acc_now = 1'b0;
      if (rst) begin
         stall_prev = 1'b0;
         return;
      end
      if (stall_prev)
         chk("hold", {out_valid, out_y, out_x2, out_err}, prev_bundle);
      if (track_drop && !drop_seen && !in_ready) begin
         drop_seen = 1'b1;
         chk("drop_pending", 288'(accepted - emitted), 288'd2);
      end
      if (in_valid && in_ready) begin
         sb.push_back(model_vec(in_data));
         accepted++;
         acc_now = 1'b1;
      end
      if (out_valid && out_ready) begin
         emitted++;
         if (sb.size() == 0) begin
            chk("spurious_out", 288'd1, 288'd0);
         end else begin
            exp_t e = sb.pop_front();
            chk("sb_y", 288'(out_y), 288'(e.y));
            chk("sb_x2", 288'(out_x2), 288'(e.x2));
            chk("sb_err", 288'(out_err), 288'(e.err));
         end
      end
      stall_prev  = out_valid && !out_ready;
      prev_bundle = {out_valid, out_y, out_x2, out_err};
   endtask

   task automatic tick();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx, base, cyc;
      logic [127:0] items[8];

      rst = 1'b1; in_valid = 1'b1; in_data = rand_vec(); out_ready = 1'b1;
      h_in_valid = 1'b0; h_in_data = '0; h_out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_out_valid", 288'(out_valid), 288'd0);
      chk("rst_outputs", {out_y, out_x2, out_err}, 288'd0);
      chk("rst_in_ready", 288'(in_ready), 288'd1);

      // Latency and scalar normal values in lanes 0..2
      in_data = {rand_op(), 32'h40800000, 32'h00800000, 32'h3F800000};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("lat_not_yet", 288'(out_valid), 288'd0);
      tick();
      chk("lat_valid", 288'(out_valid), 288'd1);
      chk("one_y", 288'(out_y[31:0]), 288'h3F7759DF);
      chk("one_x2", 288'(out_x2[31:0]), 288'h3F000000);
      chk("one_err", 288'(out_err[2:0]), 288'd0);
      chk("minnorm_y", 288'(out_y[63:32]), 288'h5EF759DF);
      chk("minnorm_x2", 288'(out_x2[63:32]), 288'h00400000);
      chk("four_y", 288'(out_y[95:64]), 288'h3EF759DF);
      chk("four_x2", 288'(out_x2[95:64]), 288'h40000000);
      tick();
      chk("empty_after", 288'(out_valid), 288'd0);

      // Special values, one per lane
      in_data = {32'h7FC00001, 32'h7F800000, 32'hBF800000, 32'h00000000};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      chk("spec_err", 288'(out_err), 288'({3'd4, 3'd3, 3'd2, 3'd1}));
      chk("spec_y", 288'(out_y), 288'({32'h7FC00000, 32'h00000000, 32'h7FC00000, 32'h7F800000}));
      chk("spec_x2", 288'(out_x2), 288'd0);
      tick();

      // Eight back-to-back with out_ready low in cycles 3-6
      for (int i = 0; i < 8; i++) items[i] = {rand_op(), rand_op(), rand_op(), {1'b0, 8'(i + 100), 23'($urandom)}};
      idx = 0; base = emitted; cyc = 1; track_drop = 1'b1; drop_seen = 1'b0;
      while (!(idx == 8 && emitted == base + 8) && cyc <= 60) begin
         in_valid  = (idx < 8);
         in_data   = items[idx < 8 ? idx : 7];
         out_ready = !(cyc >= 3 && cyc <= 6);
         tick();
         if (acc_now) idx++;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1; track_drop = 1'b0;
      chk("b2b_accepted", 288'(idx), 288'd8);
      chk("b2b_emitted", 288'(emitted - base), 288'd8);
      chk("b2b_drop_seen", 288'(drop_seen), 288'd1);
      chk("b2b_sb_empty", 288'(sb.size()), 288'd0);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = rand_vec();
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
      chk("rand_drained", 288'(sb.size()), 288'd0);
      chk("rand_count", 288'(accepted), 288'(emitted));

      // Reset with both stages full
      out_ready = 1'b0; in_valid = 1'b1; in_data = rand_vec();
      for (int i = 0; i < 10 && in_ready; i++) tick();
      chk("full_in_ready", 288'(in_ready), 288'd0);
      chk("full_out_valid", 288'(out_valid), 288'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      sb.delete();
      chk("mid_rst_valid", 288'(out_valid), 288'd0);
      chk("mid_rst_outputs", {out_y, out_x2, out_err}, 288'd0);
      chk("mid_rst_in_ready", 288'(in_ready), 288'd1);
      out_ready = 1'b1;
      base = emitted;
      repeat (6) tick();
      chk("no_stale", 288'(emitted - base), 288'd0);

      // Half-precision instance
      h_in_data = 16'h3C00; h_in_valid = 1'b1;
      tick();
      h_in_valid = 1'b0;
      tick();
      chk("h_valid", 288'(h_out_valid), 288'd1);
      chk("h_y", 288'(h_out_y), 288'h3BBA);
      chk("h_x2", 288'(h_out_x2), 288'h3800);
      chk("h_err", 288'(h_out_err), 288'd0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
